ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch sequencer for the multicycle RISC-V core. On request from the main control FSM it issues one word read to instruction memory over a req/gnt/rvalid handshake. It pulses `IRwr` to the instruction register in the exact cycle the read data is valid, then reports completion. It also detects misaligned PCs, supports flushing an in-flight fetch, and optionally times out a stalled memory.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in REQ+WAIT before a timeout fault. Range 1..255; only used with `IFETCH_TIMEOUT_EN`.
- `CNT_W`, default 16: width of the completed-fetch counter.

Ports (direction, width, meaning):
- `clk` in 1: the single clock; everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_req` in 1: level request from the main FSM; accepted only in IDLE.
- `pc` in 32: fetch address, sampled on acceptance.
- `flush` in 1: abort the current fetch.
- `fault_ack` in 1: clears ERR.
- `im_req` out 1: memory read request.
- `im_addr` out 32: registered fetch address.
- `im_gnt` in 1: memory accepted the request.
- `im_rvalid` in 1: memory read data valid this cycle.
- `IRwr` out 1: instruction-register write enable.
- `fetch_done` out 1: one-cycle completion pulse.
- `busy` out 1: state is not IDLE.
- `fault` out 1: state is ERR.
- `fault_cause` out 2: 00 none, 01 misaligned, 10 timeout.
- `fetch_cnt` out CNT_W: completed fetches, wraps modulo 2^CNT_W.

## Operation
States are IDLE, REQ, WAIT, DONE and ERR.

- **IDLE**
  - If `fetch_req` is high, `pc` is loaded into `addr_q`.
  - If `pc[1:0]` != 0, the next state is ERR with cause 01, and no memory request is issued.
  - Otherwise the next state is REQ.
- **REQ**
  - `im_req`=1 and `im_addr`=`addr_q`.
  - `im_gnt`=1 moves to WAIT.
  - `flush`=1 with `im_gnt`=0 moves to IDLE; the request is withdrawn and no done is reported.
  - `flush`=1 together with `im_gnt`=1 moves to WAIT with `drop_q` set.
- **WAIT**
  - `im_req`=0.
  - On `im_rvalid`=1: `IRwr` = `!drop_q` (combinational, same cycle). If `drop_q`=0 the next state is DONE; if `drop_q`=1 it is IDLE and `drop_q` clears.
  - `flush` in WAIT sets `drop_q`; the memory response is still consumed. `flush` in the same cycle as `im_rvalid` suppresses `IRwr`.
- **DONE**
  - `fetch_done`=1 and `fetch_cnt` increments.
  - Always returns to IDLE; a `fetch_req` seen in DONE is ignored until IDLE.
- **ERR**
  - `fault`=1 and `fault_cause` is held.
  - `fault_ack` moves to IDLE and clears `fault_cause`.
  - `flush` has no effect in ERR.
- `fetch_req` is ignored in every state except IDLE. `im_gnt` and `im_rvalid` are ignored outside REQ and WAIT respectively.
- `flush` in IDLE has no effect. If `flush` and `fetch_req` are both high in IDLE, `flush` wins: the request is not accepted.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State is IDLE; `addr_q`, `im_addr`, `fetch_cnt` and the timeout counter are 0.
  - `im_req`, `IRwr`, `fetch_done`, `busy`, `fault` and `drop_q` are 0; `fault_cause`=00.
  - Reset in mid-fetch abandons the transaction; a later `im_rvalid` from the old fetch is ignored in IDLE.
- Best case: acceptance at cycle 0 edge; `im_req` high in cycle 1; `im_gnt` in cycle 1; `im_rvalid` in cycle 2 with `IRwr` in cycle 2; `fetch_done` in cycle 3; IDLE in cycle 4.
- `IRwr` is Mealy and coincides exactly with `im_rvalid`, so the IR captures `im_dout` on that edge.
- `im_req`, `im_addr`, `fetch_done`, `busy`, `fault` and `fault_cause` are decoded from registered state, so they are glitch-free.
- `im_addr` is stable for the whole REQ/WAIT window.

## Configuration
- `IFETCH_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches `TIMEOUT` with no `im_gnt` in REQ or no `im_rvalid` in WAIT that cycle, the next state is ERR with cause 10 and `im_req` drops.
  - A handshake in the same cycle as the timeout wins.
- `IFETCH_TIMEOUT_EN` undefined: there is no counter, REQ and WAIT wait indefinitely, and cause 10 never occurs.

## Test plan
- Reset, then `pc`=0x0000_0040 with `fetch_req`, `im_gnt` immediate, `im_rvalid` one cycle later:
  - `im_addr`=0x40.
  - `IRwr` is high only in the `im_rvalid` cycle.
  - `fetch_done` pulses the next cycle and `fetch_cnt`=1.
- `pc`=0x0000_0042: ERR with `fault_cause`=01 and `im_req` never asserted; `fault_ack` returns to IDLE with cause 00.
- `im_gnt` delayed 3 cycles, `im_rvalid` delayed 5: `im_req` is held exactly 4 cycles, `im_addr` is stable throughout, and there is one `IRwr`.
- Flush behaviour:
  - `flush` in REQ before grant: returns to IDLE with no `IRwr` and no `fetch_done`.
  - `flush` in WAIT: the later `im_rvalid` produces no `IRwr`, then IDLE.
- With `IFETCH_TIMEOUT_EN` and `TIMEOUT`=4, `im_gnt` held low: ERR with cause 10 after 4 REQ cycles. Repeat with `im_gnt` arriving in the 4th cycle: no fault.
- Assert `rst_n` low while in WAIT: all outputs return to reset values immediately; a stale `im_rvalid` afterwards produces no `IRwr`.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: one word read per fetch_req over req/gnt/rvalid, IRwr on rvalid.
// Optional stalled-memory timeout is enabled with `define IFETCH_TIMEOUT_EN.
module ifetch_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic [31:0]      pc,
  input  logic             flush,
  input  logic             fault_ack,
  output logic             im_req,
  output logic [31:0]      im_addr,
  input  logic             im_gnt,
  input  logic             im_rvalid,
  output logic             IRwr,
  output logic             fetch_done,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [CNT_W-1:0] fetch_cnt
);

  // Handshake: im_req is held from entry to REQ until the cycle im_gnt is seen high;
  // exactly one im_rvalid cycle is then consumed in WAIT, whether or not it is dropped.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [31:0]      addr_q;
  logic             drop_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] cnt_q;
  logic             to_hit;

`ifdef IFETCH_TIMEOUT_EN
  logic [7:0] tcnt_q;

  // Counts REQ+WAIT cycles; zero on the first REQ cycle, so TIMEOUT cycles end at TIMEOUT-1.
  assign to_hit = (tcnt_q >= 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (state == S_REQ || state == S_WAIT) begin
      tcnt_q <= tcnt_q + 8'd1;
    end else begin
      tcnt_q <= '0;
    end
  end
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      drop_q  <= 1'b0;
      cause_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_req && !flush) begin
            addr_q <= pc;
            if (pc[1:0] != 2'b00) begin
              state   <= S_ERR;
              cause_q <= 2'b01;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A grant always wins; a flush alongside it only marks the response for dropping.
          if (im_gnt) begin
            state  <= S_WAIT;
            drop_q <= flush;
          end else if (flush) begin
            state <= S_IDLE;
          end else if (to_hit) begin
            state   <= S_ERR;
            cause_q <= 2'b10;
          end
        end
        S_WAIT: begin
          if (im_rvalid) begin
            drop_q <= 1'b0;
            if (drop_q || flush) begin
              state <= S_IDLE;
            end else begin
              state <= S_DONE;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (to_hit) begin
            state   <= S_ERR;
            cause_q <= 2'b10;
            drop_q  <= 1'b0;
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_ERR: begin
          if (fault_ack) begin
            state   <= S_IDLE;
            cause_q <= 2'b00;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign im_req      = (state == S_REQ);
  assign im_addr     = addr_q;
  assign fetch_done  = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign fault       = (state == S_ERR);
  assign fault_cause = cause_q;
  assign fetch_cnt   = cnt_q;

  // Mealy so the IR captures read data on the same edge the memory presents it.
  assign IRwr = (state == S_WAIT) && im_rvalid && !drop_q && !flush;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: vector table of fetch transactions plus hand-written corner sequences.
// Build with +define+IFETCH_TIMEOUT_EN to add the timeout sequence.
module tb_ifetch_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        fault_ack = 1'b0;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        IRwr;
  logic        fetch_done;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [15:0] fetch_cnt;

  ifetch_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .fault_ack(fault_ack), .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .IRwr(IRwr), .fetch_done(fetch_done), .busy(busy),
    .fault(fault), .fault_cause(fault_cause), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int gnt_dly;     // REQ cycles without grant before the granting cycle
    int rv_dly;      // WAIT cycles without rvalid before the rvalid cycle
    int flush_req;   // REQ cycle (1-based) carrying flush, 0 = none
    int flush_wait;  // WAIT cycle (1-based) carrying flush, 0 = none
    int exp_req;
    int exp_irwr;
    int exp_done;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          req_cnt = 0;
  int          irwr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] cur_addr = '0;
  logic [15:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: counts outputs and pops the scoreboard on every IR write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (im_req) begin
        req_cnt++;
        check("im_addr_stable", im_addr, cur_addr);
      end
      if (fetch_done) done_cnt++;
      if (IRwr) begin
        irwr_cnt++;
        if (exp_q.size() == 0) check("irwr_unexpected", 32'd1, 32'd0);
        else check("ir_addr", im_addr, exp_q.pop_front());
      end
    end
  end

  function automatic bit keep(vec_t v);
`ifdef IFETCH_TIMEOUT_EN
    int max_nh;
    if (v.flush_req > 0 && v.flush_req <= v.gnt_dly) max_nh = v.flush_req - 1;
    else if (v.rv_dly > 0) max_nh = v.gnt_dly + v.rv_dly;
    else max_nh = v.gnt_dly - 1;
    return max_nh < TO - 1;
`else
    return (v.exp_req >= 0);
`endif
  endfunction

  // Memory model: grants and returns data according to the vector's delays.
  task automatic fetch_txn(input vec_t v, output bit ok);
    int phase;
    int k;
    cur_addr  = v.pc;
    fetch_req = 1'b1;
    pc        = v.pc;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    pc        = $urandom;
    phase = 1;
    k     = 1;
    for (int c = 0; c < 64 && phase != 0; c++) begin
      im_gnt    = (phase == 1) && (k == v.gnt_dly + 1);
      im_rvalid = (phase == 2) && (k == v.rv_dly + 1);
      flush     = ((phase == 1) && (k == v.flush_req)) || ((phase == 2) && (k == v.flush_wait));
      @(posedge clk); #1;
      if (phase == 1) begin
        if (im_gnt) begin
          phase = 2;
          k     = 1;
        end else if (flush) begin
          phase = 0;
        end else begin
          k++;
        end
      end else begin
        if (im_rvalid) phase = 0;
        else k++;
      end
    end
    ok        = (phase == 0);
    im_gnt    = 1'b0;
    im_rvalid = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [31:0] r;
    int          g;
    int          d;
    vec_t        tbl[$];

    tbl.push_back('{32'h0000_0040, 0, 0, 0, 0, 1, 1, 1});
    tbl.push_back('{32'h0000_0100, 3, 4, 0, 0, 4, 1, 1});
    tbl.push_back('{32'h0000_0200, 5, 0, 2, 0, 2, 0, 0});
    tbl.push_back('{32'h0000_0300, 0, 3, 0, 2, 1, 0, 0});
    tbl.push_back('{32'h0000_0400, 1, 2, 2, 0, 2, 0, 0});
    tbl.push_back('{32'h0000_0500, 0, 2, 0, 3, 1, 0, 0});
    tbl.push_back('{32'h0000_0700, 3, 0, 0, 0, 4, 1, 1});
    for (int i = 0; i < 4; i++) begin
      r      = $urandom;
      r[1:0] = 2'b00;
      g      = $urandom_range(0, 3);
      d      = $urandom_range(0, 3);
      tbl.push_back('{r, g, d, 0, 0, g + 1, 1, 1});
    end
    foreach (tbl[i]) if (keep(tbl[i])) vecs.push_back(tbl[i]);

    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_im_req", im_req, 0);
    check("rst_im_addr", im_addr, 0);
    check("rst_irwr", IRwr, 0);
    check("rst_done", fetch_done, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_cause", fault_cause, 0);
    check("rst_cnt", fetch_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven transactions
    foreach (vecs[i]) begin
      req_cnt  = 0;
      irwr_cnt = 0;
      done_cnt = 0;
      if (vecs[i].exp_irwr != 0) exp_q.push_back(vecs[i].pc);
      fetch_txn(vecs[i], ok);
      check("txn_complete", ok, 1);
      repeat (3) @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 16'(vecs[i].exp_done);
      @(negedge clk);
      check("req_cycles", req_cnt, vecs[i].exp_req);
      check("irwr_count", irwr_cnt, vecs[i].exp_irwr);
      check("done_count", done_cnt, vecs[i].exp_done);
      check("scoreboard_empty", exp_q.size(), 0);
      check("fetch_cnt", fetch_cnt, exp_cnt);
      check("idle_after", busy, 0);
      @(posedge clk); #1;
    end

    // Misaligned pc: fault without a memory request; flush ignored in ERR
    req_cnt   = 0;
    cur_addr  = 32'h0000_0042;
    fetch_req = 1'b1;
    pc        = 32'h0000_0042;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    check("mis_fault", fault, 1);
    check("mis_cause", fault_cause, 2'b01);
    check("mis_busy", busy, 1);
    repeat (2) @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("mis_hold", fault, 1);
    check("mis_hold_cause", fault_cause, 2'b01);
    @(posedge clk); #1 fault_ack = 1'b1;
    @(posedge clk); #1 fault_ack = 1'b0;
    @(negedge clk);
    check("ack_fault", fault, 0);
    check("ack_cause", fault_cause, 2'b00);
    check("ack_busy", busy, 0);
    check("mis_no_req", req_cnt, 0);

    // flush together with fetch_req in IDLE blocks acceptance
    @(posedge clk); #1;
    fetch_req = 1'b1;
    flush     = 1'b1;
    pc        = 32'h0000_0080;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", busy, 0);
    check("flush_idle_req", im_req, 0);

`ifdef IFETCH_TIMEOUT_EN
    // Grant never arrives: fault after TO REQ cycles
    @(posedge clk); #1;
    req_cnt   = 0;
    cur_addr  = 32'h0000_0600;
    fetch_req = 1'b1;
    pc        = 32'h0000_0600;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    repeat (TO) @(posedge clk);
    #1;
    @(negedge clk);
    check("to_fault", fault, 1);
    check("to_cause", fault_cause, 2'b10);
    check("to_req_drop", im_req, 0);
    check("to_req_cycles", req_cnt, TO);
    @(posedge clk); #1 fault_ack = 1'b1;
    @(posedge clk); #1 fault_ack = 1'b0;
    @(negedge clk);
    check("to_ack", fault, 0);
`endif

    // Reset while in WAIT with rvalid present: IR write vanishes at once
    @(posedge clk); #1;
    irwr_cnt  = 0;
    cur_addr  = 32'h0000_0900;
    fetch_req = 1'b1;
    pc        = 32'h0000_0900;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    im_gnt    = 1'b1;
    @(posedge clk); #1;
    im_gnt    = 1'b0;
    im_rvalid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("wrst_irwr", IRwr, 0);
    check("wrst_busy", busy, 0);
    check("wrst_im_req", im_req, 0);
    check("wrst_im_addr", im_addr, 0);
    check("wrst_cnt", fetch_cnt, 0);
    check("wrst_fault", fault, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 im_rvalid = 1'b0;
    @(negedge clk);
    check("stale_rvalid_irwr", irwr_cnt, 0);
    check("stale_rvalid_busy", busy, 0);
    check("final_scoreboard", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
